// File: rtl/can_bus_model.sv
// can_bus_model: shared CAN bus line model for simulation and FPGA test.
// Resolves the wired-AND of all node transmit lines (0 = dominant), registers
// it as bus_level, and returns it to each node through a per-node tapped delay
// line. It also provides a disconnect mask, receive-side fault injection,
// bus-idle detection, a sticky stuck-dominant flag and a dominant-edge counter.
//
// Ports:
//   can_clk, can_rst_n  clock and asynchronous active-low reset
//   can_tx[N]           node transmit lines (0 = dominant)
//   can_rx[N]           node receive lines (combinational tap select / injection)
//   tx_disable[N]       1 = node disconnected; its tx is treated as recessive
//   node_delay[N*DW]    per-node delay in cycles; node i at [i*DW +: DW]
//   inj_en/inj_val[N]   receive-side override per node
//   clr_flags           clears dom_timeout and edge_count
//   bus_level           registered bus level
//   bus_idle            recessive for at least IDLE_BITS bits
//   dom_timeout         sticky stuck-dominant flag
//   edge_count[16]      recessive-to-dominant transition count (wraps)
module can_bus_model #(
  parameter int unsigned NUM_NODES        = 2,
  parameter int unsigned MAX_DELAY        = 15,
  parameter int unsigned CLKS_PER_BIT     = 10,
  parameter int unsigned IDLE_BITS        = 11,
  parameter int unsigned DOM_TIMEOUT_BITS = 17,
  localparam int unsigned DW              = $clog2(MAX_DELAY + 1)
) (
  input  logic                    can_clk,
  input  logic                    can_rst_n,
  input  logic [NUM_NODES-1:0]    can_tx,
  output logic [NUM_NODES-1:0]    can_rx,
  input  logic [NUM_NODES-1:0]    tx_disable,
  input  logic [NUM_NODES*DW-1:0] node_delay,
  input  logic [NUM_NODES-1:0]    inj_en,
  input  logic [NUM_NODES-1:0]    inj_val,
  input  logic                    clr_flags,
  output logic                    bus_level,
  output logic                    bus_idle,
  output logic                    dom_timeout,
  output logic [15:0]             edge_count
);

  localparam int unsigned IDLE_TH = IDLE_BITS * CLKS_PER_BIT;
  localparam int unsigned DOM_TH  = DOM_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned REC_W   = $clog2(IDLE_TH + 1);
  localparam int unsigned DOM_W   = $clog2(DOM_TH + 1);
  localparam logic [REC_W-1:0] REC_MAX = REC_W'(IDLE_TH);
  localparam logic [DOM_W-1:0] DOM_MAX = DOM_W'(DOM_TH);
  // Clamp logic is only needed when DW can encode values beyond MAX_DELAY.
  localparam bit NEED_CLAMP = ((2 ** DW) - 1) > MAX_DELAY;

  logic                 bus_raw;
  logic                 fall_edge;
  logic [MAX_DELAY:1]   taps;
  logic [MAX_DELAY:0]   tap_vec;
  logic [REC_W-1:0]     rec_cnt, rec_nxt;
  logic [DOM_W-1:0]     dom_cnt, dom_nxt;
  logic                 dom_set;

  // Wired-AND resolution; disconnected nodes read as recessive.
  assign bus_raw   = &(can_tx | tx_disable);
  assign fall_edge = bus_level & ~bus_raw;
  assign tap_vec   = {taps, bus_level};

  // Per-node tap select with combinational injection override.
  for (genvar i = 0; i < NUM_NODES; i++) begin : g_rx
    logic [DW-1:0] d_raw;
    logic [DW-1:0] d_sel;
    assign d_raw = node_delay[i*DW +: DW];
    if (NEED_CLAMP) begin : g_clamp
      assign d_sel = (d_raw > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : d_raw;
    end else begin : g_noclamp
      assign d_sel = d_raw;
    end
    assign can_rx[i] = inj_en[i] ? inj_val[i] : tap_vec[d_sel];
  end

  // Saturating run-length counters for recessive and dominant levels.
  always_comb begin
    rec_nxt = '0;
    dom_nxt = '0;
    if (bus_level) begin
      rec_nxt = (rec_cnt == REC_MAX) ? rec_cnt : rec_cnt + REC_W'(1);
    end else begin
      dom_nxt = (dom_cnt == DOM_MAX) ? dom_cnt : dom_cnt + DOM_W'(1);
    end
  end

  // Set only on the edge that reaches the threshold so a clear can stick.
  assign dom_set = (dom_nxt == DOM_MAX) && (dom_cnt != DOM_MAX);

  // Bus level, delay line, counters and flags.
  always_ff @(posedge can_clk or negedge can_rst_n) begin
    if (!can_rst_n) begin
      bus_level   <= 1'b1;
      taps        <= '1;
      rec_cnt     <= '0;
      dom_cnt     <= '0;
      bus_idle    <= 1'b0;
      dom_timeout <= 1'b0;
      edge_count  <= '0;
    end else begin
      bus_level <= bus_raw;
      taps[1]   <= bus_level;
      for (int k = 2; k <= int'(MAX_DELAY); k++) begin
        taps[k] <= taps[k-1];
      end
      rec_cnt  <= rec_nxt;
      dom_cnt  <= dom_nxt;
      bus_idle <= (rec_nxt >= REC_MAX);
      if (dom_set) begin
        dom_timeout <= 1'b1;
      end else if (clr_flags) begin
        dom_timeout <= 1'b0;
      end
      if (clr_flags) begin
        edge_count <= fall_edge ? 16'd1 : 16'd0;
      end else if (fall_edge) begin
        edge_count <= edge_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_can_bus_model.sv
// Directed self-checking bench for can_bus_model (3 nodes, MAX_DELAY=7,
// CLKS_PER_BIT=4, IDLE_BITS=11, DOM_TIMEOUT_BITS=17).
module tb_can_bus_model;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 3;

  logic          can_clk = 1'b0;
  logic          can_rst_n;
  logic [N-1:0]  can_tx;
  logic [N-1:0]  can_rx;
  logic [N-1:0]  tx_disable;
  logic [N*DW-1:0] node_delay;
  logic [N-1:0]  inj_en;
  logic [N-1:0]  inj_val;
  logic          clr_flags;
  logic          bus_level;
  logic          bus_idle;
  logic          dom_timeout;
  logic [15:0]   edge_count;

  int checks = 0;
  int errors = 0;

  can_bus_model #(
    .NUM_NODES(3), .MAX_DELAY(7), .CLKS_PER_BIT(4),
    .IDLE_BITS(11), .DOM_TIMEOUT_BITS(17)
  ) dut (
    .can_clk(can_clk), .can_rst_n(can_rst_n), .can_tx(can_tx), .can_rx(can_rx),
    .tx_disable(tx_disable), .node_delay(node_delay), .inj_en(inj_en),
    .inj_val(inj_val), .clr_flags(clr_flags), .bus_level(bus_level),
    .bus_idle(bus_idle), .dom_timeout(dom_timeout), .edge_count(edge_count)
  );

  always #5 can_clk = ~can_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge can_clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_rx;

    can_rst_n  = 1'b0;
    can_tx     = 3'b111;
    tx_disable = 3'b000;
    node_delay = '0;
    inj_en     = 3'b000;
    inj_val    = 3'b111;
    clr_flags  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_rx", 32'(can_rx), 32'h7);
    check("rst_level", 32'(bus_level), 32'h1);
    check("rst_idle", 32'(bus_idle), 32'h0);
    check("rst_domto", 32'(dom_timeout), 32'h0);
    check("rst_edges", 32'(edge_count), 32'h0);

    // Idle detection: 0 for 43 edges, 1 from the 44th
    can_rst_n = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      check("idle_run", 32'(bus_idle), (k >= 44) ? 32'h1 : 32'h0);
    end
    check("idle_rx", 32'(can_rx), 32'h7);
    check("idle_edges", 32'(edge_count), 32'h0);

    // Delay skew: node2=7, node1=3, node0=0; node1 dominant for one cycle
    node_delay = {3'd7, 3'd3, 3'd0};
    can_tx = 3'b101;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) can_tx = 3'b111;
      exp_rx = {(c != 8), (c != 4), (c != 1)};
      check("skew_rx", 32'(can_rx), 32'(exp_rx));
      if (c == 1) begin
        check("skew_edges", 32'(edge_count), 32'h1);
        check("skew_idle_hold", 32'(bus_idle), 32'h1);
      end
      if (c == 2) check("skew_idle_drop", 32'(bus_idle), 32'h0);
    end

    // Disconnect: node0 masked while dominant
    pulse_clr();
    check("clr_edges", 32'(edge_count), 32'h0);
    tx_disable = 3'b001;
    can_tx = 3'b110;
    for (int c = 1; c <= 100; c++) begin
      tick();
      check("disc_level", 32'(bus_level), 32'h1);
      check("disc_rx", 32'(can_rx), 32'h7);
    end
    check("disc_edges", 32'(edge_count), 32'h0);
    check("disc_domto", 32'(dom_timeout), 32'h0);
    can_tx = 3'b111;
    tx_disable = 3'b000;
    tick();

    // Stuck dominant: threshold 68 edges with bus_level sampled 0
    can_tx = 3'b011;
    for (int c = 1; c <= 70; c++) begin
      tick();
      if (c == 1)  check("stuck_level", 32'(bus_level), 32'h0);
      if (c == 68) check("stuck_before", 32'(dom_timeout), 32'h0);
      if (c == 69) check("stuck_set", 32'(dom_timeout), 32'h1);
    end
    can_tx = 3'b111;
    for (int c = 1; c <= 5; c++) tick();
    check("stuck_sticky", 32'(dom_timeout), 32'h1);
    check("stuck_edges", 32'(edge_count), 32'h1);
    pulse_clr();
    check("stuck_clr_to", 32'(dom_timeout), 32'h0);
    check("stuck_clr_edges", 32'(edge_count), 32'h0);

    // Clear coinciding with the threshold edge: set wins
    can_tx = 3'b011;
    for (int c = 1; c <= 68; c++) tick();
    check("coin_before", 32'(dom_timeout), 32'h0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("coin_set_wins", 32'(dom_timeout), 32'h1);
    check("coin_edges", 32'(edge_count), 32'h0);
    can_tx = 3'b111;
    for (int c = 1; c <= 3; c++) tick();

    // Clear coinciding with a falling edge yields a count of 1
    can_tx = 3'b110;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    can_tx = 3'b111;
    check("edge_clr_coin", 32'(edge_count), 32'h1);
    check("edge_clr_to", 32'(dom_timeout), 32'h0);
    for (int c = 1; c <= 10; c++) tick();

    // Injection: combinational override, also during reset
    inj_en  = 3'b010;
    inj_val = 3'b000;
    #1;
    check("inj_rx", 32'(can_rx), 32'h5);
    check("inj_level", 32'(bus_level), 32'h1);
    can_rst_n = 1'b0;
    #1;
    check("inj_rst_rx", 32'(can_rx), 32'h5);
    inj_en = 3'b000;
    #1;
    check("inj_off_rx", 32'(can_rx), 32'h7);
    tick();
    can_rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) tick();

    // Reset mid-frame with delays {7,3,0}
    node_delay = {3'd7, 3'd3, 3'd0};
    can_tx = 3'b101;
    for (int c = 1; c <= 10; c++) tick();
    check("mid_pre_level", 32'(bus_level), 32'h0);
    check("mid_pre_edges", 32'(edge_count), 32'h1);
    #2;
    can_rst_n = 1'b0;
    #1;
    check("mid_rx", 32'(can_rx), 32'h7);
    check("mid_level", 32'(bus_level), 32'h1);
    check("mid_edges", 32'(edge_count), 32'h0);
    check("mid_idle", 32'(bus_idle), 32'h0);
    check("mid_domto", 32'(dom_timeout), 32'h0);
    can_tx = 3'b111;
    tick();
    can_rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check("mid_post_rx", 32'(can_rx), 32'h7);
    end
    check("mid_post_edges", 32'(edge_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
